// File: rtl/fp32_to_fp16_pipe.sv
// fp32 -> fp16 narrowing converter, RNE, 2-stage valid/ready pipe.
// Ports: clk, reset, in_valid/in_ready/in_data, out_valid/out_ready/out_data, out_ovf/out_unf/out_inexact.
module fp32_to_fp16_pipe #(
  parameter bit FLUSH_DENORM = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);

  typedef enum logic [1:0] {
    K_FIN,
    K_NAN,
    K_INF,
    K_OVF
  } kind_e;

  typedef struct packed {
    logic       sign;
    kind_e      kind;
    logic [4:0] exp;
    logic [9:0] mant;
    logic       grd;
    logic       stk;
  } s1_t;

  logic adv;

  logic               in_s;
  logic [7:0]         in_e;
  logic [22:0]        in_m;
  logic signed [8:0]  e16;
  logic [23:0]        sig;
  logic [4:0]         sh;
  logic [35:0]        sh_v;
  logic               is_max;
  logic               is_zero;
  logic               is_ovf;
  logic               is_norm;
  logic               is_sub;
  s1_t                s1_c;

  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_valid_d;
  logic s1_valid_q;

  logic [14:0] rnd;
  logic        inc;
  logic        inx;
  logic [15:0] res_data;
  logic        res_ovf;
  logic        res_unf;
  logic        res_inx;

  logic        out_valid_d;
  logic        out_valid_q;
  logic [15:0] out_data_d;
  logic [15:0] out_data_q;
  logic        out_ovf_d;
  logic        out_ovf_q;
  logic        out_unf_d;
  logic        out_unf_q;
  logic        out_inexact_d;
  logic        out_inexact_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Stage 1: unpack and classify; produce the 10-bit
  // pre-round mantissa, target exponent, guard and sticky.
  always_comb begin
    in_s = in_data[31];
    in_e = in_data[30:23];
    in_m = in_data[22:0];
    e16  = $signed({1'b0, in_e}) - 9'sd112;
    sig  = {1'b1, in_m};

    // Right shift for the subnormal path, clamped at 25
    // (everything lands in sticky beyond that).
    if (in_e > 8'd101) begin
      sh = 5'(8'd126 - in_e);
    end else begin
      sh = 5'd25;
    end
    // sig sits above 26 spare bits: [35:26] mant,
    // [25] guard, [24:0] sticky after the shift.
    sh_v = 36'({sig, 26'b0} >> sh);

    is_max  = (in_e == 8'hFF);
    is_zero = (in_e == 8'h00);
    is_ovf  = !is_max && (e16 >= 9'sd31);
    is_norm = (e16 >= 9'sd1) && (e16 <= 9'sd30);
    is_sub  = !is_zero && (e16 <= 9'sd0);

    s1_c      = '0;
    s1_c.sign = in_s;
    s1_c.kind = K_FIN;
    unique case (1'b1)
      is_max: begin
        s1_c.kind = (in_m != 23'd0) ? K_NAN : K_INF;
      end
      is_zero: begin
        // fp32 subnormals flush: only sticky survives.
        s1_c.stk = |in_m;
      end
      is_ovf: begin
        s1_c.kind = K_OVF;
      end
      is_norm: begin
        s1_c.exp  = e16[4:0];
        s1_c.mant = in_m[22:13];
        s1_c.grd  = in_m[12];
        s1_c.stk  = |in_m[11:0];
      end
      is_sub: begin
        s1_c.mant = sh_v[35:26];
        s1_c.grd  = sh_v[25];
        s1_c.stk  = |sh_v[24:0];
      end
      default: begin
        s1_c.kind = K_FIN;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = s1_c;
      end
    end
  end

  // Stage 2: round-to-nearest-even and pack.
  always_comb begin
    inc = s1_q.grd & (s1_q.stk | s1_q.mant[0]);
    // Exponent and mantissa as one field so a mantissa
    // carry bumps the exponent: 0x3FF subnormal rolls to
    // min normal, exponent 30 all-ones rolls to inf.
    rnd = {s1_q.exp, s1_q.mant} + {14'd0, inc};
    inx = s1_q.grd | s1_q.stk;

    res_data = '0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_inx  = 1'b0;
    unique case (s1_q.kind)
      K_NAN: begin
        res_data = {s1_q.sign, 15'h7E00};
      end
      K_INF: begin
        res_data = {s1_q.sign, 15'h7C00};
      end
      K_OVF: begin
        res_data = {s1_q.sign, 15'h7C00};
        res_ovf  = 1'b1;
        res_inx  = 1'b1;
      end
      K_FIN: begin
        res_data = {s1_q.sign, rnd};
        res_ovf  = (rnd[14:10] == 5'h1F);
        res_inx  = inx;
        res_unf  = inx && (rnd[14:10] == 5'h00);
        if (FLUSH_DENORM && (rnd[14:10] == 5'h00) &&
            (rnd[9:0] != 10'd0)) begin
          res_data = {s1_q.sign, 15'h0000};
          res_unf  = 1'b1;
          res_inx  = 1'b1;
        end
      end
      default: begin
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    out_inexact_d = out_inexact_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d    = res_data;
        out_ovf_d     = res_ovf;
        out_unf_d     = res_unf;
        out_inexact_d = res_inx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'h0000;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;
  assign out_unf     = out_unf_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// Bench for fp32_to_fp16_pipe: directed vector table,
// stalled stream with scoreboard, and mid-stream reset.
module tb_fp32_to_fp16_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  fp32_to_fp16_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  int checks;
  int failures;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h",
               name, idx, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {13'd0, out_data, out_ovf, out_unf, out_inexact};
  endfunction

  function automatic logic [31:0] expv(input int i);
    return {13'd0, vt[i].dout, vt[i].ovf, vt[i].unf, vt[i].inx};
  endfunction

  task automatic run_stream();
    logic [31:0] q [$];
    logic [31:0] held;
    logic        stall;
    int          sent;
    int          got;
    sent  = 0;
    got   = 0;
    stall = 1'b0;
    held  = '0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      if (stall) chk("stall_hold", cyc, obs(), held);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      in_data   = vt[(sent < 8) ? sent : 0].din;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", got, 32'd1, 32'd0);
        end else begin
          chk("stream", got, obs(), q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(expv(sent));
        sent++;
      end
      stall = out_valid && !out_ready;
      held  = obs();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 0, 32'(got), 32'd8);
    chk("stream_left", 0, 32'(q.size()), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    vt[0]  = '{32'h3F800000, 16'h3C00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h3F801000, 16'h3C00, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{32'h3F803000, 16'h3C02, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{32'h477FF000, 16'h7C00, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{32'hFF800000, 16'hFC00, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'h33800000, 16'h0001, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h33000000, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{32'h00000001, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{32'h7FC00001, 16'h7E00, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'hFF800001, 16'hFE00, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'h80000000, 16'h8000, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h7F800000, 16'h7C00, 1'b0, 1'b0, 1'b0};
    vt[12] = '{32'h47800000, 16'h7C00, 1'b1, 1'b0, 1'b1};
    vt[13] = '{32'h477FE000, 16'h7BFF, 1'b0, 1'b0, 1'b0};
    vt[14] = '{32'h387FFFFF, 16'h0400, 1'b0, 1'b0, 1'b1};
    vt[15] = '{32'h38800000, 16'h0400, 1'b0, 1'b0, 1'b0};
    vt[16] = '{32'hC0000000, 16'hC000, 1'b0, 1'b0, 1'b0};
    vt[17] = '{32'h80000001, 16'h8000, 1'b0, 1'b1, 1'b1};
    vt[18] = '{32'h33C00000, 16'h0002, 1'b0, 1'b1, 1'b1};
    vt[19] = '{32'h3F801001, 16'h3C01, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_out", 0, obs(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 0, 32'(in_ready), 32'd1);
    chk("idle_valid", 0, 32'(out_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].din;
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat1_valid", i, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat2_valid", i, 32'(out_valid), 32'd1);
      chk("vec", i, obs(), expv(i));
    end

    run_stream();

    // Mid-stream reset drops both stages.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vt[2].din;
    @(negedge clk);
    in_data = vt[3].din;
    @(negedge clk);
    chk("pre_rst_valid", 0, 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_valid", 0, 32'(out_valid), 32'd0);
    chk("mid_rst_out", 0, obs(), 32'd0);
    @(negedge clk);
    chk("drop_valid", 1, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("drop_valid", 2, 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
